// File: rtl/exp_req_arbiter.sv
// exp_req_arbiter
//   Shares one in-order exponentiation unit among N_REQ requesters. A
//   round-robin arbiter picks the next requester, issues its operand to the
//   unit and records the owner ID in a tag FIFO. Each unit result is steered
//   back to the owner at the FIFO head, with no added latency.
//
// Ports
//   clk, rst        clock, asynchronous active-high reset
//   req_valid       per-requester operand valid
//   req_enable      per-requester operand accepted (one-hot or zero)
//   req_data        packed operands, requester i at [i*X_BITS +: X_BITS]
//   rsp_valid       per-requester result valid (one-hot or zero)
//   rsp_enable      per-requester result accept
//   rsp_data        result, broadcast to all requesters
//   rsp_id          owner of the current result
//   exp_in_*        operand handshake toward the unit
//   exp_out_*       result handshake from the unit
//   err_orphan      sticky: unit result arrived with no outstanding tag
module exp_req_arbiter #(
  parameter int unsigned N_REQ     = 4,
  parameter int unsigned X_BITS    = 16,
  parameter int unsigned Y_BITS    = 16,
  parameter int unsigned TAG_DEPTH = 2
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [N_REQ-1:0]           req_valid,
  output logic [N_REQ-1:0]           req_enable,
  input  logic [N_REQ*X_BITS-1:0]    req_data,
  output logic [N_REQ-1:0]           rsp_valid,
  input  logic [N_REQ-1:0]           rsp_enable,
  output logic [Y_BITS-1:0]          rsp_data,
  output logic [$clog2(N_REQ)-1:0]   rsp_id,
  output logic                       exp_in_valid,
  input  logic                       exp_in_enable,
  output logic [X_BITS-1:0]          exp_in_data,
  input  logic                       exp_out_valid,
  output logic                       exp_out_enable,
  input  logic [Y_BITS-1:0]          exp_out_data,
  output logic                       err_orphan
);

  localparam int unsigned IdW  = $clog2(N_REQ);
  localparam int unsigned PtrW = $clog2(TAG_DEPTH);
  localparam int unsigned CntW = $clog2(TAG_DEPTH) + 1;
  localparam logic [CntW-1:0] FullCnt = CntW'(TAG_DEPTH);
  localparam logic [IdW-1:0]  LastId  = IdW'(N_REQ - 1);

  logic [IdW-1:0]  last_grant_q;
  logic [IdW-1:0]  tag_q [TAG_DEPTH];
  logic [PtrW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CntW-1:0] count_q;
  logic            err_orphan_q;

  logic [X_BITS-1:0] req_arr [N_REQ];
  logic [IdW-1:0]    winner;
  logic              found;
  logic              fifo_empty;
  logic [IdW-1:0]    head;
  logic              pop;
  logic              can_issue;
  logic              issue;

  for (genvar i = 0; i < N_REQ; i++) begin : g_unpack
    assign req_arr[i] = req_data[i*X_BITS +: X_BITS];
  end

  assign fifo_empty = (count_q == '0);
  assign head       = tag_q[rd_ptr_q];
  assign pop        = exp_out_valid & ~fifo_empty & rsp_enable[head];
  // A full FIFO may still accept a push when the head retires this cycle.
  // Issue is held off during reset so every output reads zero while rst=1.
  assign can_issue  = exp_in_enable & ((count_q < FullCnt) | pop) & ~rst;
  assign issue      = can_issue & found;
  assign err_orphan = err_orphan_q;

  // Round-robin search starting just after the last accepted grant.
  always_comb begin
    int unsigned idx;
    winner = '0;
    found  = 1'b0;
    idx    = 0;
    for (int unsigned off = 1; off <= N_REQ; off++) begin
      idx = 32'(last_grant_q) + off;
      if (idx >= N_REQ) idx = idx - N_REQ;
      if (!found && req_valid[idx]) begin
        found  = 1'b1;
        winner = IdW'(idx);
      end
    end
  end

  // Issue side. exp_in_valid is qualified by exp_in_enable through can_issue:
  // the unit captures on valid alone and would overwrite a held result.
  always_comb begin
    req_enable   = '0;
    exp_in_valid = 1'b0;
    exp_in_data  = '0;
    if (issue) begin
      req_enable[winner] = 1'b1;
      exp_in_valid       = 1'b1;
      exp_in_data        = req_arr[winner];
    end
  end

  // Response side: purely combinational steering to the head owner.
  always_comb begin
    rsp_valid      = '0;
    rsp_id         = '0;
    rsp_data       = '0;
    exp_out_enable = 1'b0;
    if (!fifo_empty) begin
      rsp_valid[head] = exp_out_valid;
      rsp_id          = head;
      rsp_data        = exp_out_data;
      exp_out_enable  = rsp_enable[head];
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      last_grant_q <= LastId;
      wr_ptr_q     <= '0;
      rd_ptr_q     <= '0;
      count_q      <= '0;
      err_orphan_q <= 1'b0;
    end else begin
      if (issue) begin
        last_grant_q <= winner;
        wr_ptr_q     <= wr_ptr_q + PtrW'(1);
      end
      if (pop) rd_ptr_q <= rd_ptr_q + PtrW'(1);
      if (issue && !pop)      count_q <= count_q + CntW'(1);
      else if (!issue && pop) count_q <= count_q - CntW'(1);
      if (exp_out_valid && fifo_empty) err_orphan_q <= 1'b1;
    end
  end

  // Tag storage needs no reset; entries are only read when count_q is non-zero.
  always_ff @(posedge clk) begin
    if (issue) tag_q[wr_ptr_q] <= winner;
  end

endmodule

// File: doc/exp_req_arbiter.md
Name: exp_req_arbiter

Overview:
- Shares one DeLugishExp exponentiation unit among N_REQ requesters using round-robin arbitration.
- Issues the granted operand to the unit through its valid/enable handshake.
- Records the owner ID of every issued operation in an in-order tag FIFO and steers each unit result back to that owner.
- Sits between the LNS MAC lanes and the shared exponentiation datapath.

Parameters:
N_REQ, 4, number of requesters (2..8)
X_BITS, 16, operand width (matches unit input)
Y_BITS, 16, result width (matches unit output)
TAG_DEPTH, 2, tag FIFO entries (power of two, >=2)

Ports:
clk  in  1  clock
rst  in  1  asynchronous reset, active-high
req_valid  in  N_REQ  per-requester operand valid
req_enable  out  N_REQ  per-requester operand accepted (one-hot or zero)
req_data  in  N_REQ*X_BITS  operands; requester i occupies bits [i*X_BITS +: X_BITS]
rsp_valid  out  N_REQ  per-requester result valid (one-hot or zero)
rsp_enable  in  N_REQ  per-requester result accept
rsp_data  out  Y_BITS  result, broadcast to all requesters
rsp_id  out  $clog2(N_REQ)  owner of current result
exp_in_valid  out  1  to unit data_in_valid
exp_in_enable  in  1  from unit data_in_enable
exp_in_data  out  X_BITS  to unit data_in
exp_out_valid  in  1  from unit data_out_valid
exp_out_enable  out  1  to unit data_out_enable
exp_out_data  in  Y_BITS  from unit data_out
err_orphan  out  1  sticky: unit result arrived with tag FIFO empty

Behaviour:
- Reset (async, rst=1): last_grant=N_REQ-1, tag FIFO empty (rd/wr pointers and count 0), err_orphan=0. All combinational outputs are then 0 (req_enable, rsp_valid, exp_in_valid, exp_out_enable), and rsp_id=0.
- Issue condition `can_issue`: exp_in_enable & (fifo_count<TAG_DEPTH | pop). pop is defined below.
- Arbitration: combinational.
  - Search req_valid starting at (last_grant+1) mod N_REQ, ascending with wrap; the first set bit is the winner.
  - If can_issue and a winner exists: req_enable[winner]=1, exp_in_valid=1, exp_in_data=req_data[winner], push winner ID into the tag FIFO.
- exp_in_valid is never asserted when exp_in_enable=0. The unit latches its valid on data_in_valid alone, so asserting it unqualified would corrupt the held result.
- last_grant updates to the winner only on an accepted issue. It holds when there is no issue.
- Response: let head = tag FIFO head.
  - With FIFO non-empty: rsp_valid[head]=exp_out_valid; rsp_id=head; rsp_data=exp_out_data; exp_out_enable=rsp_enable[head].
  - pop = exp_out_valid & fifo non-empty & rsp_enable[head].
  - Zero added latency: the response path is combinational.
- FIFO empty: exp_out_enable=0, rsp_valid=0. If exp_out_valid=1 while empty, set err_orphan (sticky until rst).
- Simultaneous push and pop: count unchanged, both pointers advance. A push into a full FIFO is allowed only in the same cycle as a pop.
- Pointers wrap modulo TAG_DEPTH. Count width is $clog2(TAG_DEPTH)+1.
- Results return in issue order, because the unit is in-order. End-to-end latency is 1 cycle (unit register) when the owner has rsp_enable=1.
- Backpressure: if the head owner holds rsp_enable=0, the unit stalls, exp_in_enable drops, and issue stops. Other requesters wait; there is no reordering.
- Non-granted requesters see req_enable=0 and must hold req_valid and req_data stable.
- Reset mid-operation: in-flight tags are discarded. Reset of the unit is the top level's responsibility. A unit result arriving after rst deasserts sets err_orphan.

Test Plan:
1. Single requester: after reset, req_valid=0001 with req_data[0]=0x0000 -> req_enable=0001 in the same cycle; next cycle rsp_valid=0001, rsp_id=0, rsp_data=unit's exp(0) output; with rsp_enable[0]=1 the FIFO returns to empty.
2. Round-robin: req_valid=1111 held for 8 cycles, all rsp_enable=1 -> grant order 0,1,2,3,0,1,2,3; each rsp_id matches the grant one cycle earlier.
3. Backpressure: grant requester 2, then hold rsp_enable[2]=0 for 5 cycles with req_valid=1011 -> rsp_valid=0100 stays high and rsp_data stays stable; no req_enable asserted; after release, the next grant goes to requester 3.
4. Sparse requests: req_valid=1001 with last_grant=0 -> grant 3, then 0, then 3; requesters 1 and 2 are never enabled.
5. Orphan: force exp_out_valid=1 with the FIFO empty -> err_orphan=1 and it stays 1 until rst; rsp_valid=0.
6. Async reset mid-stream: assert rst between clock edges during traffic -> all outputs 0 immediately; after release the first grant goes to requester 0.
